multicycle_controller: RTL and testbench

- Multi-cycle sequencer for the RV32I-subset datapath (PC, register file, ALU, immediate generator, writeback mux).
- Drives all datapath strobes from a state machine so one instruction completes over 3-5 cycles.
- Instruction fetch and data access share a single memory port through a ready handshake.
- Replaces the single-cycle combinational control path.
- Adds illegal-opcode detection and memory-timeout detection.

---
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset sequencer: drives datapath strobes over 3-5 cycles per instruction,
// shares one memory port between fetch and data access, flags illegal opcodes and memory timeouts.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_data,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       alu_src,
  output logic [3:0] alu_sel,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH} cls_t;

  state_t        st;
  cls_t          cls;
  cls_t          dec_cls;
  logic          dec_ok;
  logic [CW-1:0] wait_cnt;
  logic          illegal_q, timeout_q;
  logic          mem_phase, tmo_hit;

  logic       mem_req_c, mem_we_c, mem_sel_c, ir_we_c, pc_we_c, pc_src_c;
  logic       rf_we_c, wb_sel_c, alu_src_c, done_c;
  logic [3:0] alu_sel_c;
  logic [3:0] map_sel;
  logic       map_src;

  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b1;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: begin
        dec_cls = C_BRANCH;
        dec_ok  = (funct3[2:1] != 2'b01);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Operation select from the latched class; the instruction fields stay stable after fetch.
  always_comb begin
    map_sel = 4'b0000;
    map_src = 1'b0;
    case (cls)
      C_R: begin
        map_sel = {funct7_5, funct3};
        map_src = 1'b1;
      end
      C_I: map_sel = {funct7_5 & (funct3 == 3'b101), funct3};
      C_BRANCH: begin
        map_src = 1'b1;
        case (funct3)
          3'b000:  map_sel = 4'b1000;
          3'b001:  map_sel = 4'b1110;
          3'b100:  map_sel = 4'b0010;
          3'b101:  map_sel = 4'b1001;
          3'b110:  map_sel = 4'b1010;
          3'b111:  map_sel = 4'b1111;
          default: map_sel = 4'b0000;
        endcase
      end
      default: ;
    endcase
  end

  assign mem_phase = (st == S_FETCH) || (st == S_MEM);
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && mem_phase && !mem_ready && (wait_cnt == TLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_FETCH;
      cls       <= C_R;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= (mem_phase && !mem_ready) ? wait_cnt + CW'(1) : '0;
      if (tmo_hit) begin
        timeout_q <= 1'b1;
        st        <= S_HALT;
      end else begin
        case (st)
          S_FETCH:  if (mem_ready) st <= S_DECODE;
          S_DECODE: begin
            cls <= dec_cls;
            if (dec_ok) st <= S_EXEC;
            else begin
              illegal_q <= 1'b1;
              st        <= S_HALT;
            end
          end
          S_EXEC: begin
            case (cls)
              C_BRANCH:        st <= S_FETCH;
              C_LOAD, C_STORE: st <= S_MEM;
              default:         st <= S_WB;
            endcase
          end
          S_MEM:    if (mem_ready) st <= (cls == C_STORE) ? S_FETCH : S_WB;
          S_WB:     st <= S_FETCH;
          S_HALT:   st <= S_HALT;
          default:  st <= S_FETCH;
        endcase
      end
    end
  end

  always_comb begin
    mem_req_c = 1'b0; mem_we_c = 1'b0; mem_sel_c = 1'b0; ir_we_c = 1'b0;
    pc_we_c   = 1'b0; pc_src_c = 1'b0; rf_we_c   = 1'b0; wb_sel_c = 1'b0;
    alu_src_c = 1'b0; alu_sel_c = 4'b0000; done_c = 1'b0;
    case (st)
      S_FETCH: begin
        mem_req_c = 1'b1;
        ir_we_c   = mem_ready;
      end
      S_EXEC: begin
        alu_sel_c = map_sel;
        alu_src_c = map_src;
        if (cls == C_BRANCH) begin
          pc_we_c  = 1'b1;
          pc_src_c = zero;
          done_c   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_sel_c = 1'b1;
        mem_we_c  = (cls == C_STORE);
        if (mem_ready && cls == C_STORE) begin
          pc_we_c = 1'b1;
          done_c  = 1'b1;
        end
      end
      S_WB: begin
        rf_we_c   = 1'b1;
        wb_sel_c  = (cls == C_LOAD);
        alu_sel_c = map_sel;
        alu_src_c = map_src;
        pc_we_c   = 1'b1;
        done_c    = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are combinational from a state that resets to FETCH, so gate them while in reset.
  assign mem_req      = rst_n & mem_req_c;
  assign mem_we       = rst_n & mem_we_c;
  assign mem_sel_data = rst_n & mem_sel_c;
  assign ir_we        = rst_n & ir_we_c;
  assign pc_we        = rst_n & pc_we_c;
  assign pc_src       = rst_n & pc_src_c;
  assign rf_we        = rst_n & rf_we_c;
  assign wb_sel       = rst_n & wb_sel_c;
  assign alu_src      = rst_n & alu_src_c;
  assign alu_sel      = {4{rst_n}} & alu_sel_c;
  assign instr_done   = rst_n & done_c;
  assign state        = st;
  assign illegal      = illegal_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state and strobe tables per instruction type.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic       mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, rf_we, wb_sel, alu_src;
  logic [3:0] alu_sel;
  logic [2:0] state;
  logic       instr_done, illegal, timeout;

  int checks = 0;
  int fails  = 0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  localparam logic [13:0] MR = 14'h2000, MW = 14'h1000, MS = 14'h0800, IR = 14'h0400;
  localparam logic [13:0] PW = 14'h0200, PS = 14'h0100, RF = 14'h0080, WS = 14'h0040;
  localparam logic [13:0] AS = 14'h0020, DN = 14'h0001;

  wire [13:0] outv = {mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, rf_we, wb_sel,
                      alu_src, alu_sel, instr_done};

  function automatic logic [13:0] A(input logic [3:0] s);
    return {9'd0, s, 1'b0};
  endfunction

  multicycle_controller #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel_data(mem_sel_data), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_src(alu_src), .alu_sel(alu_sel), .state(state),
    .instr_done(instr_done), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_I; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || outv !== 14'h0 || illegal !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset: state=%0d out=%h ill=%b tmo=%b, required 0/0000/0/0",
               state, outv, illegal, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    logic [2:0]  es[4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [13:0] eo[4] = '{MR | IR, 14'h0, 14'h0, RF | PW | DN};
    opcode = OP_I; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== es[c] || outv !== eo[c]) begin
        fails++;
        $display("FAIL addi cyc%0d: state=%0d out=%h, required state=%0d out=%h",
                 c, state, outv, es[c], eo[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0]  ops[3] = '{OP_R, OP_I, OP_I};
    logic [2:0]  f3s[3] = '{3'b000, 3'b101, 3'b000};
    logic        f7s[3] = '{1'b1, 1'b1, 1'b1};
    logic [3:0]  sel[3] = '{4'b1000, 4'b1101, 4'b0000};
    logic [13:0] src[3] = '{AS, 14'h0, 14'h0};
    logic [2:0]  es[4]  = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [13:0] eo[4];
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i]; funct3 = f3s[i]; funct7_5 = f7s[i]; mem_ready = 1'b1;
      eo = '{MR | IR, 14'h0, src[i] | A(sel[i]), src[i] | A(sel[i]) | RF | PW | DN};
      for (int c = 0; c < 4; c++) begin
        #1;
        checks++;
        if (state !== es[c] || outv !== eo[c]) begin
          fails++;
          $display("FAIL alu_op%0d cyc%0d: state=%0d out=%h, required state=%0d out=%h",
                   i, c, state, outv, es[c], eo[c]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_load();
    logic        rd[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  es[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic [13:0] eo[8] = '{MR | IR, 14'h0, 14'h0, MR | MS, MR | MS, MR | MS, MR | MS,
                           RF | WS | PW | DN};
    opcode = OP_LD; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = rd[c];
      #1;
      checks++;
      if (state !== es[c] || outv !== eo[c]) begin
        fails++;
        $display("FAIL load cyc%0d: state=%0d out=%h, required state=%0d out=%h",
                 c, state, outv, es[c], eo[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [2:0]  es[4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [13:0] eo[4] = '{MR | IR, 14'h0, 14'h0, MR | MS | MW | PW | DN};
    opcode = OP_ST; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== es[c] || outv !== eo[c]) begin
        fails++;
        $display("FAIL store cyc%0d: state=%0d out=%h, required state=%0d out=%h",
                 c, state, outv, es[c], eo[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3s[4] = '{3'b000, 3'b001, 3'b100, 3'b111};
    logic        zs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0]  sel[4] = '{4'b1000, 4'b1110, 4'b0010, 4'b1111};
    logic [2:0]  es[3]  = '{3'd0, 3'd1, 3'd2};
    logic [13:0] eo[3];
    for (int i = 0; i < 4; i++) begin
      opcode = OP_BR; funct3 = f3s[i]; funct7_5 = 1'b0; zero = zs[i]; mem_ready = 1'b1;
      eo = '{MR | IR, 14'h0, AS | A(sel[i]) | PW | (zs[i] ? PS : 14'h0) | DN};
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++;
        if (state !== es[c] || outv !== eo[c]) begin
          fails++;
          $display("FAIL branch%0d cyc%0d: state=%0d out=%h, required state=%0d out=%h",
                   i, c, state, outv, es[c], eo[c]);
        end
        @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [6:0]  ops[2] = '{7'h7F, OP_BR};
    logic [2:0]  f3s[2] = '{3'b000, 3'b010};
    logic [2:0]  es[5]  = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd5};
    logic [13:0] eo[5]  = '{MR | IR, 14'h0, 14'h0, 14'h0, 14'h0};
    logic        ei[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i]; funct3 = f3s[i]; funct7_5 = 1'b0; mem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #1;
        checks++;
        if (state !== es[c] || outv !== eo[c] || illegal !== ei[c]) begin
          fails++;
          $display("FAIL illegal%0d cyc%0d: state=%0d out=%h ill=%b, required %0d/%h/%b",
                   i, c, state, outv, illegal, es[c], eo[c], ei[c]);
        end
        @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || outv !== 14'h0 || illegal !== 1'b0) begin
        fails++;
        $display("FAIL illegal_clear%0d: state=%0d out=%h ill=%b, required 0/0000/0",
                 i, state, outv, illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic test_timeout();
    opcode = OP_I; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #1;
      checks++;
      if (state !== 3'd0 || outv !== MR || timeout !== 1'b0) begin
        fails++;
        $display("FAIL timeout_wait cyc%0d: state=%0d out=%h tmo=%b, required 0/%h/0",
                 c, state, outv, timeout, MR);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== 3'd5 || outv !== 14'h0 || timeout !== 1'b1) begin
        fails++;
        $display("FAIL timeout_halt cyc%0d: state=%0d out=%h tmo=%b, required 5/0000/1",
                 c, state, outv, timeout);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (timeout !== 1'b0 || state !== 3'd0) begin
      fails++;
      $display("FAIL timeout_clear: state=%0d tmo=%b, required 0/0", state, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Ready arrives on the 15th wait cycle of both FETCH and MEM: no timeout either time.
  task automatic test_ready_at_limit();
    logic [2:0] exp_st;
    int c = 0;
    opcode = OP_LD; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int k = 0; k < 33; k++) begin
      if (k < 15)       exp_st = 3'd0;
      else if (k == 15) exp_st = 3'd1;
      else if (k == 16) exp_st = 3'd2;
      else if (k < 32)  exp_st = 3'd3;
      else              exp_st = 3'd4;
      mem_ready = (k == 14) || (k == 31);
      #1;
      checks++;
      if (state !== exp_st || timeout !== 1'b0) begin
        fails++;
        $display("FAIL ready_at_limit cyc%0d: state=%0d tmo=%b, required %0d/0",
                 k, state, timeout, exp_st);
      end
      c++;
      @(negedge clk);
    end
    checks++;
    if (c != 33 || state !== 3'd0) begin
      fails++;
      $display("FAIL ready_at_limit_end: state=%0d, required 0", state);
    end
  endtask

  task automatic test_reset_mid_mem();
    opcode = OP_LD; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b0;
    end
    #1;
    checks++;
    if (state !== 3'd3 || outv !== (MR | MS)) begin
      fails++;
      $display("FAIL mid_mem_pre: state=%0d out=%h, required 3/%h", state, outv, MR | MS);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || outv !== 14'h0) begin
      fails++;
      $display("FAIL mid_mem_reset: state=%0d out=%h, required 0/0000", state, outv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || outv !== MR) begin
      fails++;
      $display("FAIL mid_mem_release: state=%0d out=%h, required 0/%h", state, outv, MR);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu_ops();
    test_load();
    test_store();
    test_branch();
    test_illegal();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
